unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbitrates a single-port, variable-latency unified memory between the pipeline's instruction-fetch port and its data (load/store) port. It latches the winning request, drives the memory handshake and returns read data with a one-cycle acknowledge. It also raises a pipeline stall while any requester is waiting. It sits between the pipelined CPU core's iaddr/idata and daddr/dwdata/we/drdata buses and a single shared memory.

## Interface
- IMAX_WAIT, 4, consecutive data grants tolerated while a fetch is pending before the fetch is forced ahead (≥1)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  32  fetch address
- i_flush  in  1  discard pending/in-flight fetch (branch redirect)
- i_ack  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  32  fetched instruction, held until next fetch ack
- d_req  in  1  data request; held with payload stable until d_ack
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_we  in  4  byte write enables; 0 = read
- d_ack  out  1  one-cycle pulse: access done, d_rdata valid for reads
- d_rdata  out  32  load data; updated on read completion only
- m_req  out  1  memory request, registered
- m_addr  out  32  latched address
- m_wdata  out  32  latched write data
- m_we  out  4  latched byte enables
- m_rdata  in  32  memory read data, valid when m_ready=1
- m_ready  in  1  memory completes the current request this cycle
- stall  out  1  combinational: (i_req & ~i_ack & ~i_flush) | (d_req & ~d_ack)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, IBUSY, DBUSY.
- IDLE: selects a winner from the requests sampled this cycle.
  - Data wins by default.
  - Fetch wins if d_req=0, or if wait_cnt==IMAX_WAIT.
  - A fetch with i_flush=1 is not eligible that cycle.
  - On the grant edge: latch addr/wdata/we into m_*, set m_req=1, go to IBUSY or DBUSY.
  - For a fetch, m_we=0 and m_wdata=0.
- IBUSY/DBUSY: m_* held constant. On the edge where m_ready=1 is sampled:
  - m_req←0, state←IDLE.
  - Owner's ack←1 for one cycle.
  - Read data captured into i_rdata (fetch) or d_rdata (data read). d_rdata is unchanged on writes.
- Flush: i_flush=1 at any cycle in IBUSY sets a kill flag.
  - The memory transaction still completes normally.
  - i_ack and the i_rdata update are suppressed.
  - The kill flag clears on return to IDLE.
- wait_cnt, width $clog2(IMAX_WAIT+1):
  - Increments on each data grant while i_req=1 and i_flush=0, saturating at IMAX_WAIT.
  - Clears on a fetch grant, or in any cycle where i_req=0.
- Reset: state IDLE, wait_cnt 0, kill 0. All outputs 0: m_req, m_addr, m_wdata, m_we, i_ack, d_ack, i_rdata, d_rdata, busy.
- Reset mid-transaction aborts immediately; no ack is issued. Memory must tolerate m_req dropping.

## Timing
- Grant occurs at edge E0, with m_req=1 from cycle 1.
- If m_ready=1 in cycle k (k≥1), then:
  - ack=1 and data are valid in cycle k+1.
  - State is IDLE in cycle k+1.
- The earliest next grant is at the end of cycle k+1, so minimum spacing is 2 cycles per access.
- The requester sees ack in cycle k+1. It may keep req high to issue a back-to-back request, but that request is only re-evaluated from cycle k+2. Arbitration ignores the owner's req in the ack cycle.
- Requests arriving during BUSY wait and are arbitrated in the IDLE cycle after completion.
- m_ready sampled while IDLE is ignored.
- stall is combinational, same cycle as the inputs. It drops in the ack cycle.
- Simultaneous i_req and d_req in IDLE with wait_cnt<IMAX_WAIT: data granted, fetch waits.

## Test plan
- Single fetch: i_addr=0x100, m_ready delayed 3 cycles, m_rdata=0x00500093 → m_req high 3 cycles, i_ack one cycle later, i_rdata=0x00500093, stall high until ack.
- Store then load: d_we=4'b1111, d_addr=0x200, d_wdata=0xDEADBEEF; then d_we=0, m_rdata=0xDEADBEEF → m_we=4'hF on the first, d_rdata unchanged after the store and 0xDEADBEEF after the load.
- Contention: i_req and d_req high together, m_ready immediate → data served first, fetch granted in the next IDLE; 2-cycle spacing between acks.
- Starvation (IMAX_WAIT=4): d_req held high continuously plus pending i_req → exactly 4 data grants, then a fetch grant, then wait_cnt=0.
- Flush in flight: fetch granted, i_flush pulsed in IBUSY, m_ready later → no i_ack, i_rdata keeps its old value, busy drops, next request served.
- Reset mid-DBUSY: reset asserted → next cycle all outputs 0, state IDLE; a subsequent fetch completes normally.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the CPU core's fetch/data ports, the arbiter and the
// shared single-port memory.
//   slave  : arbiter view (takes core requests and memory responses, drives
//            acks, read data, the memory request, stall and busy)
//   master : environment view (core plus memory), the mirror of slave
interface unified_mem_arbiter_if;
  // Instruction-fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_ack;
  logic [31:0] i_rdata;
  // Data (load/store) port
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_we;
  logic        d_ack;
  logic [31:0] d_rdata;
  // Shared memory port
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_we;
  logic [31:0] m_rdata;
  logic        m_ready;
  // Pipeline status
  logic        stall;
  logic        busy;

  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_addr, d_wdata, d_we, m_rdata, m_ready,
    output i_ack, i_rdata, d_ack, d_rdata, m_req, m_addr, m_wdata, m_we, stall, busy
  );

  modport master (
    output i_req, i_addr, i_flush, d_req, d_addr, d_wdata, d_we, m_rdata, m_ready,
    input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_addr, m_wdata, m_we, stall, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one variable-latency single-port memory between the fetch port
// and the data port. The winner's request is latched onto m_*, held until the
// memory signals m_ready, and the owner then gets a one-cycle ack with read
// data. Data wins by default; a fetch is forced ahead after IMAX_WAIT
// consecutive data grants.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : unified_mem_arbiter_if.slave (fetch, data, memory, stall, busy)
module unified_mem_arbiter #(
  parameter int IMAX_WAIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);

  localparam int WCW = $clog2(IMAX_WAIT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(IMAX_WAIT);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           kill_q, kill_d;
  logic           m_req_q, m_req_d;
  logic [31:0]    m_addr_q, m_addr_d;
  logic [31:0]    m_wdata_q, m_wdata_d;
  logic [3:0]     m_we_q, m_we_d;
  logic           i_ack_q, i_ack_d;
  logic           d_ack_q, d_ack_d;
  logic [31:0]    i_rdata_q, i_rdata_d;
  logic [31:0]    d_rdata_q, d_rdata_d;

  logic i_elig, d_elig, grant_i, grant_d;

  // A requester's req is ignored in its own ack cycle so that a held req is
  // only treated as a new request from the following cycle.
  always_comb begin
    i_elig  = bus.i_req & ~bus.i_flush & ~i_ack_q;
    d_elig  = bus.d_req & ~d_ack_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      // The fetch-wins test looks at the raw d_req: a data requester holding
      // req through its ack cycle still blocks the fetch, so the cycle is left
      // idle rather than handed to the fetch. This keeps the starvation
      // counter the only way a fetch can overtake continuous data traffic.
      if (i_elig && (!bus.d_req || wait_cnt_q == WMAX)) begin
        grant_i = 1'b1;
      end else if (d_elig) begin
        grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    m_req_d   = m_req_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_we_d    = m_we_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (grant_i) begin
          m_req_d   = 1'b1;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
          m_we_d    = '0;
          state_d   = IBUSY;
        end else if (grant_d) begin
          m_req_d   = 1'b1;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          m_we_d    = bus.d_we;
          state_d   = DBUSY;
        end
      end
      IBUSY: begin
        if (bus.i_flush) kill_d = 1'b1;
        if (bus.m_ready) begin
          m_req_d = 1'b0;
          state_d = IDLE;
          kill_d  = 1'b0;
          // A flush in the completion cycle itself also discards the result.
          if (!kill_q && !bus.i_flush) begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.m_rdata;
          end
        end
      end
      DBUSY: begin
        if (bus.m_ready) begin
          m_req_d = 1'b0;
          state_d = IDLE;
          d_ack_d = 1'b1;
          if (m_we_q == 4'b0000) d_rdata_d = bus.m_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Consecutive data grants seen by a waiting fetch, saturating at IMAX_WAIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.i_req || grant_i) begin
      wait_cnt_d = '0;
    end else if (grant_d && !bus.i_flush && wait_cnt_q != WMAX) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      kill_q     <= 1'b0;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_we_q     <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      kill_q     <= kill_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_we_q     <= m_we_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_we    = m_we_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.stall   = (bus.i_req & ~i_ack_q & ~bus.i_flush) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   mem_lat;

  unified_mem_arbiter_if bus();

  unified_mem_arbiter #(.IMAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected read data per port, pushed by the stimulus, popped on each ack.
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic [31:0] grant_log[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: raises m_ready after m_req has been seen for mem_lat cycles.
  int   lat_cnt;
  logic m_req_prev;
  always @(negedge clk) begin
    if (reset || !bus.m_req) begin
      bus.m_ready = 1'b0;
      lat_cnt = 0;
    end else if (!bus.m_ready) begin
      lat_cnt++;
      if (lat_cnt >= mem_lat) begin
        logic [31:0] old;
        old = mem.exists(bus.m_addr) ? mem[bus.m_addr] : 32'h0;
        bus.m_rdata = old;
        for (int b = 0; b < 4; b++)
          if (bus.m_we[b]) old[b*8 +: 8] = bus.m_wdata[b*8 +: 8];
        if (bus.m_we != 4'b0) mem[bus.m_addr] = old;
        bus.m_ready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard compare on acks, log of granted addresses.
  always @(negedge clk) begin
    if (reset) begin
      m_req_prev = 1'b0;
    end else begin
      if (bus.i_ack) begin
        if (exp_i.size() == 0) check("i_ack_unexpected", 32'd1, 32'd0);
        else check("i_rdata", bus.i_rdata, exp_i.pop_front());
      end
      if (bus.d_ack) begin
        if (exp_d.size() == 0) check("d_ack_unexpected", 32'd1, 32'd0);
        else check("d_rdata", bus.d_rdata, exp_d.pop_front());
      end
      if (bus.m_req && !m_req_prev) grant_log.push_back(bus.m_addr);
      m_req_prev = bus.m_req;
    end
  end

  task automatic wait_ack(input bit is_i, output int mreq_cyc, output int stall_lo);
    bit seen;
    seen = 1'b0;
    mreq_cyc = 0;
    stall_lo = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = is_i ? bus.i_ack : bus.d_ack;
      if (!seen) begin
        if (bus.m_req) mreq_cyc++;
        if (!bus.stall) stall_lo++;
      end
    end
    if (!seen) check(is_i ? "i_ack_timeout" : "d_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic contention(input logic [31:0] ia, input logic [31:0] da,
                            input logic [31:0] iv, input logic [31:0] dv);
    int mc, sl, t_d, t_i;
    mem[ia] = iv;
    mem[da] = dv;
    mem_lat = 1;
    @(negedge clk);
    grant_log.delete();
    bus.i_req = 1'b1; bus.i_addr = ia;
    bus.d_req = 1'b1; bus.d_addr = da; bus.d_we = 4'b0; bus.d_wdata = '0;
    exp_d.push_back(dv);
    exp_i.push_back(iv);
    wait_ack(1'b0, mc, sl);
    t_d = cyc;
    bus.d_req = 1'b0;
    wait_ack(1'b1, mc, sl);
    t_i = cyc;
    bus.i_req = 1'b0;
    check("ack_spacing", 32'(t_i - t_d), 32'd2);
    check("grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      check("grant_first_data", grant_log[0], da);
      check("grant_second_fetch", grant_log[1], ia);
    end
  endtask

  initial begin
    int mc, sl, nd, nack;
    bit done;
    checks = 0; errors = 0; cyc = 0; mem_lat = 1;
    reset = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.i_flush = 0;
    bus.d_req = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_we = '0;
    bus.m_ready = 0; bus.m_rdata = '0;
    mem[32'h100] = 32'h00500093;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_m_req", 32'(bus.m_req), 32'd0);
    check("rst_m_addr", bus.m_addr, 32'd0);
    check("rst_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    check("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
    check("rst_busy_stall", {30'd0, bus.busy, bus.stall}, 32'd0);

    // Single fetch, memory latency 3
    mem_lat = 3;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    exp_i.push_back(32'h00500093);
    #1 check("stall_on_req", 32'(bus.stall), 32'd1);
    wait_ack(1'b1, mc, sl);
    check("fetch_m_req_cycles", 32'(mc), 32'd3);
    check("fetch_stall_gap", 32'(sl), 32'd0);
    check("stall_in_ack", 32'(bus.stall), 32'd0);
    bus.i_req = 1'b0;

    // Store then load
    mem_lat = 2;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; bus.d_we = 4'hF;
    exp_d.push_back(32'h0);
    @(negedge clk);
    check("store_m_we", {28'd0, bus.m_we}, 32'hF);
    check("store_m_wdata", bus.m_wdata, 32'hDEADBEEF);
    check("store_m_addr", bus.m_addr, 32'h200);
    check("store_busy", 32'(bus.busy), 32'd1);
    wait_ack(1'b0, mc, sl);
    bus.d_req = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_wdata = '0;
    exp_d.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("load_m_we", {28'd0, bus.m_we}, 32'h0);
    wait_ack(1'b0, mc, sl);
    bus.d_req = 1'b0;

    // Contention: data first, fetch in the following idle cycle
    contention(32'h104, 32'h204, 32'h11111111, 32'h22222222);

    // Starvation: continuous data traffic against a pending fetch
    mem[32'h300] = 32'h33333333;
    mem[32'h108] = 32'h44444444;
    mem_lat = 1;
    @(negedge clk);
    grant_log.delete();
    bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.d_we = 4'h0;
    bus.i_req = 1'b1; bus.i_addr = 32'h108;
    repeat (4) exp_d.push_back(32'h33333333);
    exp_i.push_back(32'h44444444);
    nd = 0; done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (bus.d_ack) nd++;
      if (bus.i_ack) done = 1'b1;
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    check("starve_fetch_acked", 32'(done), 32'd1);
    check("starve_data_grants", 32'(nd), 32'd4);
    check("starve_grant_count", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() == 5) check("starve_fetch_last", grant_log[4], 32'h108);

    // After the forced fetch the counter restarts: data wins again
    contention(32'h10C, 32'h20C, 32'h55555555, 32'h66666666);

    // Flush during an in-flight fetch
    mem[32'h110] = 32'h77777777;
    mem_lat = 4;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h110;
    @(negedge clk);
    check("flush_busy", 32'(bus.busy), 32'd1);
    bus.i_flush = 1'b1; bus.i_req = 1'b0;
    @(negedge clk);
    bus.i_flush = 1'b0;
    done = 1'b0; nack = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.i_ack) nack++;
      if (!bus.busy) done = 1'b1;
    end
    check("flush_busy_drop", 32'(done), 32'd1);
    check("flush_no_ack", 32'(nack), 32'd0);
    check("flush_rdata_kept", bus.i_rdata, 32'h55555555);
    mem[32'h114] = 32'h88888888;
    mem_lat = 1;
    bus.i_req = 1'b1; bus.i_addr = 32'h114;
    exp_i.push_back(32'h88888888);
    wait_ack(1'b1, mc, sl);
    bus.i_req = 1'b0;

    // Reset in the middle of a data transaction
    mem_lat = 5;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_addr = 32'h204; bus.d_we = 4'hF; bus.d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1; bus.d_req = 1'b0; bus.d_we = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_m", {bus.m_req, bus.m_we, bus.busy, bus.i_ack, bus.d_ack}, 32'd0);
    check("rstmid_addr_wdata", bus.m_addr | bus.m_wdata, 32'd0);
    check("rstmid_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
    mem_lat = 2;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    exp_i.push_back(32'h00500093);
    wait_ack(1'b1, mc, sl);
    bus.i_req = 1'b0;
    check("post_rst_m_req_cycles", 32'(mc), 32'd2);
    repeat (3) @(negedge clk);
    check("exp_i_drained", 32'(exp_i.size()), 32'd0);
    check("exp_d_drained", 32'(exp_d.size()), 32'd0);
    check("mem_untouched_by_abort", mem[32'h204], 32'h22222222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
